// File: rtl/saph_types.sv
// Shared rasterizer front-end types: vertex record, shape encodings and the
// shape command handed to the rasterizer core.
package saph_types;

  localparam logic [1:0] SAPH_SHAPE_LINE = 2'd0;
  localparam logic [1:0] SAPH_SHAPE_TRI  = 2'd1;
  localparam logic [1:0] SAPH_SHAPE_RECT = 2'd2;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } vertex;

  typedef bit [1:0] shape_t;

  typedef struct packed {
    shape_t shape;
    vertex  v0;
    vertex  v1;
    vertex  v2;
  } rast_cmd;

endpackage

// File: rtl/saph_shape_seq.sv
// Groups transformed vertices into complete line/tri/rect shapes and issues them
// to the rasterizer. Optional strip mode is built when SAPH_SHAPE_STRIP_EN is defined.
module saph_shape_seq
  import saph_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [1:0]                           cmd_shape,
  input  logic [15:0]                          cmd_count,
`ifdef SAPH_SHAPE_STRIP_EN
  input  logic                                 cmd_strip,
`endif
  input  logic                                 vtx_valid,
  output logic                                 vtx_ready,
  input  logic [$bits(saph_types::vertex)-1:0] vtx_data,
  output logic                                 rast_valid,
  input  logic                                 rast_ready,
  output logic [$bits(saph_types::rast_cmd)-1:0] rast_cmd,
  output logic                                 busy,
  output logic [CNT_W-1:0]                     shape_cnt,
  output logic                                 err_shape
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_ISSUE
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          shape_q, shape_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [1:0]          idx_q, idx_d;
  saph_types::vertex   v0_q, v0_d;
  saph_types::vertex   v1_q, v1_d;
  saph_types::vertex   v2_q, v2_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
`ifdef SAPH_SHAPE_STRIP_EN
  logic                strip_q, strip_d;
  logic                cont_q, cont_d;
`endif

  saph_types::vertex   vtx_in;
  logic [1:0]          last_idx;
  saph_types::rast_cmd cmd_out;

  assign vtx_in   = vtx_data;
  assign last_idx = (shape_q == SAPH_SHAPE_TRI) ? 2'd2 : 2'd1;

  always_comb begin
    state_d     = state_q;
    shape_d     = shape_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    v2_d        = v2_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
`ifdef SAPH_SHAPE_STRIP_EN
    strip_d     = strip_q;
    cont_d      = cont_q;
`endif
    cmd_ready   = 1'b0;
    vtx_ready   = 1'b0;
    rast_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_shape == 2'b11) begin
            err_d = 1'b1;
          end else if (cmd_count != 16'd0) begin
            shape_d     = cmd_shape;
            remaining_d = cmd_count;
            idx_d       = 2'd0;
            state_d     = S_COLLECT;
`ifdef SAPH_SHAPE_STRIP_EN
            // Rectangles have no strip form, so they always collect as a list.
            strip_d     = cmd_strip && (cmd_shape != SAPH_SHAPE_RECT);
            cont_d      = 1'b0;
`endif
          end
        end
      end

      S_COLLECT: begin
        vtx_ready = 1'b1;
        if (vtx_valid) begin
`ifdef SAPH_SHAPE_STRIP_EN
          if (cont_q) begin
            // Strip continuation: slide the window by one vertex.
            v0_d = v1_q;
            if (shape_q == SAPH_SHAPE_TRI) begin
              v1_d = v2_q;
              v2_d = vtx_in;
            end else begin
              v1_d = vtx_in;
            end
            state_d = S_ISSUE;
          end else begin
`endif
            case (idx_q)
              2'd0:    v0_d = vtx_in;
              2'd1:    v1_d = vtx_in;
              default: v2_d = vtx_in;
            endcase
            idx_d = idx_q + 2'd1;
            if (idx_q == last_idx) begin
              state_d = S_ISSUE;
            end
`ifdef SAPH_SHAPE_STRIP_EN
          end
`endif
        end
      end

      S_ISSUE: begin
        rast_valid = 1'b1;
        if (rast_ready) begin
          remaining_d = remaining_q - 16'd1;
          cnt_d       = cnt_q + 1'b1;
          idx_d       = 2'd0;
`ifdef SAPH_SHAPE_STRIP_EN
          cont_d      = strip_q;
`endif
          state_d     = (remaining_q == 16'd1) ? S_IDLE : S_COLLECT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shape_q     <= 2'd0;
      remaining_q <= 16'd0;
      idx_q       <= 2'd0;
      v0_q        <= '0;
      v1_q        <= '0;
      v2_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
`ifdef SAPH_SHAPE_STRIP_EN
      strip_q     <= 1'b0;
      cont_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shape_q     <= shape_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`ifdef SAPH_SHAPE_STRIP_EN
      strip_q     <= strip_d;
      cont_q      <= cont_d;
`endif
    end
  end

  // Lines and rects only carry two vertices; the third slot is presented as zero.
  always_comb begin
    cmd_out       = '0;
    cmd_out.shape = shape_q;
    cmd_out.v0    = v0_q;
    cmd_out.v1    = v1_q;
    cmd_out.v2    = (shape_q == SAPH_SHAPE_TRI) ? v2_q : '0;
  end

  assign rast_cmd  = cmd_out;
  assign busy      = (state_q != S_IDLE);
  assign shape_cnt = cnt_q;
  assign err_shape = err_q;

endmodule

// File: tb/tb_saph_shape_seq.sv
// Scoreboard bench for saph_shape_seq: expected shapes are queued as commands and
// vertices are driven, then popped and compared at each rasterizer handshake.
module tb_saph_shape_seq;
  import saph_types::*;

  localparam int CNT_W = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_shape;
  logic [15:0]          cmd_count;
  logic                 cmd_strip;
  logic                 vtx_valid;
  logic                 vtx_ready;
  logic [31:0]          vtx_data;
  logic                 rast_valid;
  logic                 rast_ready;
  logic [$bits(saph_types::rast_cmd)-1:0] rast_cmd_s;
  logic                 busy;
  logic [CNT_W-1:0]     shape_cnt;
  logic                 err_shape;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  saph_types::rast_cmd sb[$];
  int                  hs_cyc[$];

  always #5 clk = ~clk;

  saph_shape_seq #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_shape  (cmd_shape),
    .cmd_count  (cmd_count),
`ifdef SAPH_SHAPE_STRIP_EN
    .cmd_strip  (cmd_strip),
`endif
    .vtx_valid  (vtx_valid),
    .vtx_ready  (vtx_ready),
    .vtx_data   (vtx_data),
    .rast_valid (rast_valid),
    .rast_ready (rast_ready),
    .rast_cmd   (rast_cmd_s),
    .busy       (busy),
    .shape_cnt  (shape_cnt),
    .err_shape  (err_shape)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic saph_types::rast_cmd mk(input logic [1:0] sh, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
    saph_types::rast_cmd r;
    r.shape = sh;
    r.v0    = a;
    r.v1    = b;
    r.v2    = (sh == SAPH_SHAPE_TRI) ? c : 32'd0;
    return r;
  endfunction

  // Handshake monitor: inputs are stable at the falling edge, so a valid&ready seen
  // here completes at the next rising edge.
  always @(negedge clk) begin
    saph_types::rast_cmd exp_cmd;
    cyc++;
    if (!rst && rast_valid && rast_ready) begin
      hs_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        exp_cmd = sb.pop_front();
        check("rast_cmd", rast_cmd_s, exp_cmd);
        $display("issue @%0d shape=%0d v0=%h v1=%h v2=%h", cyc, exp_cmd.shape,
                 exp_cmd.v0, exp_cmd.v1, exp_cmd.v2);
      end
    end
  end

  task automatic send_cmd(input logic [1:0] sh, input logic [15:0] cnt, input logic st);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_shape = sh;
    cmd_count = cnt;
    cmd_strip = st;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("cmd_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    $display("cmd shape=%0d count=%0d strip=%0d", sh, cnt, st);
  endtask

  task automatic send_vtx(input logic [31:0] v);
    bit ok = 0;
    vtx_valid = 1'b1;
    vtx_data  = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (vtx_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("vtx_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    vtx_valid = 1'b0;
    $display("vtx %h", v);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", 128'(cmd_ready), 128'd1);
    check("rst_vtx_ready", 128'(vtx_ready), 128'd0);
    check("rst_rast_valid", 128'(rast_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_shape_cnt", 128'(shape_cnt), 128'd0);
    check("rst_err_shape", 128'(err_shape), 128'd0);
    check("rst_rast_cmd", 128'(rast_cmd_s), 128'd0);
  endtask

  initial begin
    logic [31:0] va, vb, vc, vd, ve;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_shape = 2'd0; cmd_count = 16'd0; cmd_strip = 1'b0;
    vtx_valid = 1'b0; vtx_data = 32'd0; rast_ready = 1'b0;
    va = $urandom; vb = $urandom; vc = $urandom; vd = $urandom; ve = $urandom;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;

    // Two lines back to back, rasterizer always ready.
    rast_ready = 1'b1;
    hs_cyc.delete();
    sb.push_back(mk(SAPH_SHAPE_LINE, va, vb, 32'd0));
    sb.push_back(mk(SAPH_SHAPE_LINE, vc, vd, 32'd0));
    send_cmd(SAPH_SHAPE_LINE, 16'd2, 1'b0);
    check("vtx_ready_after_cmd", 128'(vtx_ready), 128'd1);
    check("cmd_ready_in_collect", 128'(cmd_ready), 128'd0);
    send_vtx(va);
    send_vtx(vb);
    check("rast_valid_after_last", 128'(rast_valid), 128'd1);
    send_vtx(vc);
    send_vtx(vd);
    wait_idle();
    check("line_hs_count", 128'(hs_cyc.size()), 128'd2);
    if (hs_cyc.size() == 2) check("line_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'd3);
    check("line_shape_cnt", 128'(shape_cnt), 128'd2);
    check("line_idle_cmd_ready", 128'(cmd_ready), 128'd1);

    // Triangle with the rasterizer stalling.
    rast_ready = 1'b0;
    sb.push_back(mk(SAPH_SHAPE_TRI, va, vb, vc));
    send_cmd(SAPH_SHAPE_TRI, 16'd1, 1'b0);
    send_vtx(va);
    send_vtx(vb);
    send_vtx(vc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rast_valid", 128'(rast_valid), 128'd1);
      check("stall_rast_cmd", 128'(rast_cmd_s), 128'(mk(SAPH_SHAPE_TRI, va, vb, vc)));
      check("stall_vtx_ready", 128'(vtx_ready), 128'd0);
    end
    @(posedge clk);
    #1 rast_ready = 1'b1;
    wait_idle();
    check("tri_sb_drained", 128'(sb.size()), 128'd0);
    check("tri_shape_cnt", 128'(shape_cnt), 128'd3);

    // Illegal shape, then a normal rect.
    send_cmd(2'b11, 16'd1, 1'b0);
    check("illegal_err", 128'(err_shape), 128'd1);
    check("illegal_busy", 128'(busy), 128'd0);
    check("illegal_vtx_ready", 128'(vtx_ready), 128'd0);
    sb.push_back(mk(SAPH_SHAPE_RECT, vd, ve, 32'd0));
    send_cmd(SAPH_SHAPE_RECT, 16'd1, 1'b0);
    send_vtx(vd);
    send_vtx(ve);
    wait_idle();
    check("rect_err_sticky", 128'(err_shape), 128'd1);
    check("rect_shape_cnt", 128'(shape_cnt), 128'd4);

    // Zero-count command is a no-op.
    send_cmd(SAPH_SHAPE_TRI, 16'd0, 1'b0);
    check("zero_busy", 128'(busy), 128'd0);
    check("zero_cmd_ready", 128'(cmd_ready), 128'd1);
    @(negedge clk);
    check("zero_busy_later", 128'(busy), 128'd0);
    @(posedge clk);
    #1;

    // Reset after one of three triangle vertices.
    send_cmd(SAPH_SHAPE_TRI, 16'd1, 1'b0);
    send_vtx(va);
    #2 rst = 1'b1;
    #1 check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;

    // Reset while a shape is offered must drop rast_valid at once.
    rast_ready = 1'b0;
    send_cmd(SAPH_SHAPE_LINE, 16'd1, 1'b0);
    send_vtx(va);
    send_vtx(vb);
    check("pre_rst_rast_valid", 128'(rast_valid), 128'd1);
    #2 rst = 1'b1;
    #1 check("async_rast_valid", 128'(rast_valid), 128'd0);
    check("async_rast_cmd", 128'(rast_cmd_s), 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Two list triangles: four cycles per shape.
    rast_ready = 1'b1;
    hs_cyc.delete();
    sb.push_back(mk(SAPH_SHAPE_TRI, va, vb, vc));
    sb.push_back(mk(SAPH_SHAPE_TRI, vc, vd, ve));
    send_cmd(SAPH_SHAPE_TRI, 16'd2, 1'b0);
    send_vtx(va);
    send_vtx(vb);
    send_vtx(vc);
    send_vtx(vc);
    send_vtx(vd);
    send_vtx(ve);
    wait_idle();
    check("tri2_hs_count", 128'(hs_cyc.size()), 128'd2);
    if (hs_cyc.size() == 2) check("tri_spacing", 128'(hs_cyc[1] - hs_cyc[0]), 128'd4);
    check("tri2_shape_cnt", 128'(shape_cnt), 128'd2);

`ifdef SAPH_SHAPE_STRIP_EN
    // Triangle strip: A,B,C then one new vertex per shape.
    hs_cyc.delete();
    sb.push_back(mk(SAPH_SHAPE_TRI, va, vb, vc));
    sb.push_back(mk(SAPH_SHAPE_TRI, vb, vc, vd));
    sb.push_back(mk(SAPH_SHAPE_TRI, vc, vd, ve));
    send_cmd(SAPH_SHAPE_TRI, 16'd3, 1'b1);
    send_vtx(va);
    send_vtx(vb);
    send_vtx(vc);
    send_vtx(vd);
    send_vtx(ve);
    wait_idle();
    check("strip_hs_count", 128'(hs_cyc.size()), 128'd3);
    if (hs_cyc.size() == 3) check("strip_spacing", 128'(hs_cyc[2] - hs_cyc[1]), 128'd2);
    check("strip_shape_cnt", 128'(shape_cnt), 128'd5);
`endif

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
